cell_update_sender: RTL and testbench

CELL_UPDATE_SENDER -- requirements
Module: cell_update_sender

---
 rtl/cell_update_sender_if.sv | 30 +++
 rtl/cell_update_sender.sv | 132 +++++++++++++
 tb/tb_cell_update_sender.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_update_sender_if.sv
// Report/draw-command bundle for cell_update_sender.
// The master drives cell reports and out_ready; the slave returns draw commands.
interface cell_update_sender_if;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned PX_W    = 9;
    localparam int unsigned PY_W    = 8;
    localparam int unsigned COLOR_W = 16;

    logic               in_valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [CODE_W-1:0]  obj_code;
    logic               diff;
    logic               out_valid;
    logic               out_ready;
    logic [PX_W-1:0]    out_px;
    logic [PY_W-1:0]    out_py;
    logic [COLOR_W-1:0] out_color;

    modport master (
        output in_valid, x, y, obj_code, diff, out_ready,
        input  out_valid, out_px, out_py, out_color
    );

    modport slave (
        input  in_valid, x, y, obj_code, diff, out_ready,
        output out_valid, out_px, out_py, out_color
    );
endinterface

// File: rtl/cell_update_sender.sv
// Queues changed-cell reports in an 8-deep FIFO and emits pixel draw commands (x*20, y*20, RGB565).
// Optional feature macro: CELL_SENDER_DROP_COUNT_EN enables the saturating drop_count counter.
module cell_update_sender (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    cell_update_sender_if.slave  bus,
    output logic                 full,
    output logic                 overflow,
    output logic [7:0]           drop_count
);
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned PTR_W   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned ENTRY_W = 2 * COORD_W + CODE_W;
    localparam int unsigned PX_W    = 9;
    localparam int unsigned PY_W    = 8;
    localparam int unsigned COLOR_W = 16;
    localparam int unsigned DC_W    = 8;
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(11);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nxt;
    logic                 qualify;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic [COORD_W-1:0]   head_x;
    logic [COORD_W-1:0]   head_y;
    logic [CODE_W-1:0]    head_code;

    // Out-of-grid rows are ignored outright; a qualifying report while full is a drop.
    assign full      = (count == CNT_W'(DEPTH));
    assign qualify   = bus.in_valid & enable & bus.diff & (bus.y <= Y_MAX);
    assign push      = qualify & ~full;
    assign drop      = qualify & full;
    assign pop       = (state == LOAD);
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign {head_x, head_y, head_code} = mem[rd_ptr];

    function automatic logic [COLOR_W-1:0] code_color(input logic [CODE_W-1:0] code);
        case (code)
            3'b000:  return 16'h0000;
            3'b001:  return 16'h07E0;
            3'b010:  return 16'h03E0;
            3'b011:  return 16'hF800;
            3'b100:  return 16'hFFFF;
            default: return 16'hF81F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.x, bus.y, bus.obj_code};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // SEND exit looks at the post-edge count so a same-cycle push is not missed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (bus.out_ready) state_nxt = (count_nxt != '0) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_px    <= '0;
            bus.out_py    <= '0;
            bus.out_color <= '0;
        end else begin
            bus.out_valid <= (state_nxt == SEND);
            if (state == LOAD) begin
                bus.out_px    <= (PX_W'(head_x) << 4) + (PX_W'(head_x) << 2);
                bus.out_py    <= (PY_W'(head_y) << 4) + (PY_W'(head_y) << 2);
                bus.out_color <= code_color(head_code);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef CELL_SENDER_DROP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != {DC_W{1'b1}})) begin
            drop_count <= drop_count + DC_W'(1);
        end
    end
`else
    assign drop_count = DC_W'(0);
`endif

endmodule

// File: tb/tb_cell_update_sender.sv
// Self-checking bench for cell_update_sender: directed scenarios plus randomized reports
// checked against a queue-based reference of accepted reports and their draw commands.
module tb_cell_update_sender;
    logic       tb_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       full;
    logic       overflow;
    logic [7:0] drop_count;

    cell_update_sender_if bus();

    cell_update_sender dut (
        .clk        (tb_clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .full       (full),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 tb_clk = ~tb_clk;

`ifdef CELL_SENDER_DROP_COUNT_EN
    localparam logic [7:0] EXP_DROP = 8'd1;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    typedef struct packed {
        logic [8:0]  px;
        logic [7:0]  py;
        logic [15:0] color;
    } cmd_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    cmd_t obs_q[$];
    cmd_t exp_q[$];
    int   hs_cyc[$];

    // Draw command a cell report should produce.
    function automatic cmd_t model_cmd(input int x, input int y, input int code);
        cmd_t c;
        c.px = 9'(x * 20);
        c.py = 8'(y * 20);
        case (code)
            0:       c.color = 16'h0000;
            1:       c.color = 16'h07E0;
            2:       c.color = 16'h03E0;
            3:       c.color = 16'hF800;
            4:       c.color = 16'hFFFF;
            default: c.color = 16'hF81F;
        endcase
        return c;
    endfunction

    task automatic drive(input bit v, input bit en, input bit d, input int x, input int y,
                         input int code, output bit q);
        bus.in_valid = v;
        enable       = en;
        bus.diff     = d;
        bus.x        = 4'(x);
        bus.y        = 4'(y);
        bus.obj_code = 3'(code);
        q = v && en && d && (y <= 11);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.diff     = 1'b0;
        enable       = 1'b1;
    endtask

    // One clock; records any handshake seen just before the edge.
    task automatic step();
        bit   hs;
        cmd_t c;
        hs      = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        c.px    = bus.out_px;
        c.py    = bus.out_py;
        c.color = bus.out_color;
        @(posedge tb_clk);
        #1;
        if (hs) begin
            obs_q.push_back(c);
            hs_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int quiet;
        quiet = 0;
        idle_inputs();
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (obs_q.size() >= exp_q.size() && bus.out_valid !== 1'b1) quiet++;
            else quiet = 0;
            if (quiet >= 6) break;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        hs_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.x = '0; bus.y = '0; bus.obj_code = '0;
        #2 rst = 1'b1;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if ({bus.out_px, bus.out_py, bus.out_color} !== 33'd0) begin
            failures++; $display("FAIL reset_outputs got=%0d/%0d/%h exp=0/0/0000", bus.out_px, bus.out_py, bus.out_color);
        end
        checks++;
        if ({full, overflow, drop_count} !== 10'd0) begin
            failures++; $display("FAIL reset_flags got full=%b ovf=%b dc=%0d exp=0/0/0", full, overflow, drop_count);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit q;
        obs_q.delete(); exp_q.delete();
        bus.out_ready = 1'b1;
        drive(1, 1, 1, 3, 2, 3, q);
        step();
        idle_inputs();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_lat_n got=%b exp=0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_lat_n1 got=%b exp=0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_px !== 9'd60 || bus.out_py !== 8'd40 || bus.out_color !== 16'hF800) begin
            failures++;
            $display("FAIL single_cmd got v=%b px=%0d py=%0d col=%h exp v=1 px=60 py=40 col=f800",
                     bus.out_valid, bus.out_px, bus.out_py, bus.out_color);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b exp=0", bus.out_valid); end
        checks++;
        if (obs_q.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", obs_q.size()); end
    endtask

    task automatic test_ignored();
        bit q;
        int bad_valid;
        bad_valid = 0;
        obs_q.delete(); exp_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       drive(1, 1, 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), q);
                1:       drive(1, 1, 1, $urandom_range(0, 15), $urandom_range(12, 15), $urandom_range(0, 7), q);
                default: drive(1, 0, 1, $urandom_range(0, 15), $urandom_range(0, 11), $urandom_range(0, 7), q);
            endcase
            step();
            if (bus.out_valid !== 1'b0) bad_valid++;
        end
        idle_inputs();
        repeat (4) step();
        checks++;
        if (bad_valid !== 0 || obs_q.size() !== 0) begin
            failures++; $display("FAIL ignored_valid got cycles=%0d cmds=%0d exp=0/0", bad_valid, obs_q.size());
        end
        checks++;
        if (overflow !== 1'b0 || full !== 1'b0) begin
            failures++; $display("FAIL ignored_flags got ovf=%b full=%b exp=0/0", overflow, full);
        end
    endtask

    task automatic test_overflow();
        bit q;
        int x, y, code;
        obs_q.delete(); exp_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x = $urandom_range(0, 15); y = $urandom_range(0, 11); code = $urandom_range(0, 7);
            drive(1, 1, 1, x, y, code, q);
            if (i < 9) exp_q.push_back(model_cmd(x, y, code));
            step();
            if (i == 7) begin
                checks++;
                if (full !== 1'b0) begin failures++; $display("FAIL ovf_full_8 got=%b exp=0", full); end
            end
            if (i == 8) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    failures++; $display("FAIL ovf_full_9 got full=%b ovf=%b exp=1/0", full, overflow);
                end
            end
        end
        idle_inputs();
        checks++;
        if (overflow !== 1'b1 || drop_count !== EXP_DROP) begin
            failures++; $display("FAIL ovf_drop got ovf=%b dc=%0d exp=1/%0d", overflow, drop_count, EXP_DROP);
        end
        drain(100);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL ovf_cmd_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overflow !== 1'b1 || full !== 1'b0) begin
            failures++; $display("FAIL ovf_sticky got ovf=%b full=%b exp=1/0", overflow, full);
        end
    endtask

    task automatic test_stall();
        bit   q;
        int   x, y, code, unstable;
        cmd_t held;
        do_reset();
        x = $urandom_range(0, 15); y = $urandom_range(0, 11); code = $urandom_range(0, 7);
        drive(1, 1, 1, x, y, code, q);
        exp_q.push_back(model_cmd(x, y, code));
        step();
        idle_inputs();
        for (int i = 0; i < 10 && bus.out_valid !== 1'b1; i++) step();
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_wait got=%b exp=1", bus.out_valid); end
        held = {bus.out_px, bus.out_py, bus.out_color};
        unstable = 0;
        repeat (5) begin
            step();
            if (bus.out_valid !== 1'b1 || {bus.out_px, bus.out_py, bus.out_color} !== held) unstable++;
        end
        checks++;
        if (unstable !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
        checks++;
        if (held !== exp_q[0]) begin failures++; $display("FAIL stall_value got=%h exp=%h", held, exp_q[0]); end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (obs_q.size() !== 1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_single got cmds=%0d v=%b exp=1/0", obs_q.size(), bus.out_valid);
        end
    endtask

    task automatic test_rst_mid_send();
        bit q;
        int x, y, code;
        obs_q.delete(); exp_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, $urandom_range(0, 15), $urandom_range(0, 11), $urandom_range(0, 7), q);
            step();
        end
        idle_inputs();
        step();
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || {bus.out_px, bus.out_py, bus.out_color} !== 33'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got v=%b px=%0d py=%0d col=%h full=%b exp 0/0/0/0000/0",
                     bus.out_valid, bus.out_px, bus.out_py, bus.out_color, full);
        end
        step();
        rst = 1'b0;
        obs_q.delete();
        x = $urandom_range(0, 15); y = $urandom_range(0, 11); code = $urandom_range(0, 7);
        drive(1, 1, 1, x, y, code, q);
        exp_q.push_back(model_cmd(x, y, code));
        step();
        drain(40);
        checks++;
        if (obs_q.size() !== 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
            failures++; $display("FAIL rstmid_after got cmds=%0d exp=1 cmd=%h", obs_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_corner();
        bit   q;
        cmd_t c4, c7;
        obs_q.delete(); exp_q.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive(1, 1, 1, 15, 11, c, q);
            exp_q.push_back(model_cmd(15, 11, c));
            step();
        end
        drain(60);
        checks++;
        if (obs_q.size() !== 8) begin failures++; $display("FAIL corner_count got=%0d exp=8", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL corner_cmd[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        c4 = (obs_q.size() > 4) ? obs_q[4] : '0;
        c7 = (obs_q.size() > 7) ? obs_q[7] : '0;
        checks++;
        if (c4 !== {9'd300, 8'd220, 16'hFFFF}) begin
            failures++; $display("FAIL corner_max got px=%0d py=%0d col=%h exp px=300 py=220 col=ffff", c4.px, c4.py, c4.color);
        end
        checks++;
        if (c7.color !== 16'hF81F) begin failures++; $display("FAIL corner_code7 got=%h exp=f81f", c7.color); end
    endtask

    task automatic test_back_to_back();
        bit q;
        int x, y, code, bad_gap;
        obs_q.delete(); exp_q.delete(); hs_cyc.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = $urandom_range(0, 15); y = $urandom_range(0, 11); code = $urandom_range(0, 7);
            drive(1, 1, 1, x, y, code, q);
            exp_q.push_back(model_cmd(x, y, code));
            step();
        end
        drain(60);
        checks++;
        if (hs_cyc.size() !== 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", hs_cyc.size()); end
        bad_gap = 0;
        for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 2) bad_gap++;
        checks++;
        if (bad_gap !== 0) begin failures++; $display("FAIL b2b_rate got bad_gaps=%0d exp=0", bad_gap); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_cmd[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // From an empty pipeline at most 8 accepted reports can never overflow, so acceptance is rule-based.
    task automatic test_random();
        bit q;
        int x, y, code, nq;
        obs_q.delete(); exp_q.delete();
        for (int r = 0; r < 6; r++) begin
            nq = 0;
            for (int c = 0; c < 20 && nq < 8; c++) begin
                x = $urandom_range(0, 15); y = $urandom_range(0, 15); code = $urandom_range(0, 7);
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, x, y, code, q);
                bus.out_ready = 1'($urandom_range(0, 1));
                if (q) begin
                    exp_q.push_back(model_cmd(x, y, code));
                    nq++;
                end
                step();
            end
            drain(80);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL rand_cmd[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow got=%b exp=0", overflow); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_ignored();
        test_overflow();
        test_stall();
        test_rst_mid_send();
        test_corner();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
